// File: rtl/snn_fp16_pkg.sv
// Shared FP16 constants and the accumulator state encoding for the SNN front end.
package snn_fp16_pkg;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_HALF = 16'h3800;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/synaptic_current_accumulator_if.sv
// Weight-write, spike-launch and current-pulse signals of the accumulator.
interface synaptic_current_accumulator_if #(
  parameter int N_INPUTS = 16,
  parameter int IDX_W    = $clog2(N_INPUTS)
);
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [15:0]         wr_data;
  logic                start;
  logic [N_INPUTS-1:0] spikes_in;
  logic                busy;
  logic [15:0]         current_out;
  logic                current_valid;

  modport master (
    output wr_en, wr_addr, wr_data, start, spikes_in,
    input  busy, current_out, current_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, spikes_in,
    output busy, current_out, current_valid
  );
endinterface

// File: rtl/synaptic_current_accumulator_fadd.sv
// Combinational IEEE-754 half-precision adder, round-to-nearest-even,
// with subnormal support and overflow to infinity.
module floatAdd
  import snn_fp16_pkg::*;
(
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic [15:0] sum
);
  logic [15:0] w_big, w_sml;
  logic        w_sub;
  logic [5:0]  w_eb, w_es, w_d, w_e, w_ef;
  logic [3:0]  w_sh;
  logic [13:0] w_mb, w_ms, w_ms_al, w_m, w_mn;
  logic [27:0] w_shf;
  logic [14:0] w_add;
  logic        w_inc;
  logic [11:0] w_mr;
  logic [9:0]  w_frac;

  always_comb begin
    w_big   = (floatB[14:0] > floatA[14:0]) ? floatB : floatA;
    w_sml   = (floatB[14:0] > floatA[14:0]) ? floatA : floatB;
    w_sub   = w_big[15] ^ w_sml[15];
    w_eb    = (w_big[14:10] == 5'd0) ? 6'd1 : {1'b0, w_big[14:10]};
    w_es    = (w_sml[14:10] == 5'd0) ? 6'd1 : {1'b0, w_sml[14:10]};
    // mantissa with hidden bit and guard/round/sticky positions
    w_mb    = {|w_big[14:10], w_big[9:0], 3'b000};
    w_ms    = {|w_sml[14:10], w_sml[9:0], 3'b000};
    w_d     = w_eb - w_es;
    w_sh    = (w_d > 6'd14) ? 4'd14 : w_d[3:0];
    w_shf   = {w_ms, 14'd0} >> w_sh;
    w_ms_al = {w_shf[27:15], w_shf[14] | (|w_shf[13:0])};
    w_add   = {1'b0, w_mb} + {1'b0, w_ms_al};
    w_m     = w_mb - w_ms_al;
    w_e     = w_eb;
    w_mn    = w_add[13:0];
    if (!w_sub) begin
      if (w_add[14]) begin
        w_mn = {w_add[14:2], w_add[1] | w_add[0]};
        w_e  = w_eb + 6'd1;
      end
    end else begin
      // normalise left, but never below the subnormal exponent
      w_mn = w_m;
      for (int i = 0; i < 13; i++) begin
        if (!w_mn[13] && (w_e > 6'd1)) begin
          w_mn = w_mn << 1;
          w_e  = w_e - 6'd1;
        end
      end
    end
    w_inc  = w_mn[2] & (w_mn[3] | w_mn[1] | w_mn[0]);
    w_mr   = {1'b0, w_mn[13:3]} + {11'd0, w_inc};
    w_ef   = w_e;
    w_frac = w_mr[9:0];
    if (w_mr[11]) begin
      w_ef   = w_e + 6'd1;
      w_frac = 10'd0;
    end else if (!w_mr[10]) begin
      w_ef = 6'd0;
    end
    if (&w_big[14:10])
      sum = ((|w_big[9:0]) || (w_sub && (&w_sml[14:10]))) ? FP16_QNAN : w_big;
    else if (w_sub && (w_m == 14'd0))
      sum = FP16_ZERO;
    else if (w_ef >= 6'd31)
      sum = {w_big[15], 5'h1f, 10'd0};
    else
      sum = {w_big[15], w_ef[4:0], w_frac};
  end
endmodule

// File: rtl/synaptic_current_accumulator.sv
// Sums the FP16 weights of the active synapses one per cycle and emits the
// total as a single-cycle current pulse for the LIF neuron.
module synaptic_current_accumulator
  import snn_fp16_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  synaptic_current_accumulator_if.slave bus
);
  acc_state_t          r_state;
  logic [15:0]         r_w [N_INPUTS];
  logic [N_INPUTS-1:0] r_spk;
  logic [IDX_W-1:0]    r_idx;
  logic [15:0]         r_acc;
  logic                r_busy;
  logic                r_valid;
  logic [15:0]         r_out;
  logic [15:0]         w_sum;

  floatAdd u_fadd (
    .floatA (r_acc),
    .floatB (r_w[r_idx]),
    .sum    (w_sum)
  );

  // weights only change in IDLE so a sum always sees a stable set
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++) r_w[i] <= FP16_ZERO;
    end else if (bus.wr_en && (r_state == IDLE) && (int'(bus.wr_addr) < N_INPUTS)) begin
      r_w[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_spk   <= '0;
      r_idx   <= '0;
      r_acc   <= FP16_ZERO;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_out   <= FP16_ZERO;
    end else begin
      r_valid <= 1'b0;
      r_out   <= FP16_ZERO;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_spk   <= bus.spikes_in;
            r_acc   <= FP16_ZERO;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (r_spk[r_idx]) r_acc <= w_sum;
          if (r_idx == IDX_W'(N_INPUTS - 1)) r_state <= DONE;
          else                               r_idx   <= r_idx + 1'b1;
        end
        DONE: begin
          r_valid <= 1'b1;
          r_out   <= r_acc;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.current_valid = r_valid;
  assign bus.current_out   = r_out;
endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Bench for the synaptic current accumulator: fixed vectors, corner sequences
// and random sums against a real-arithmetic FP16 model.
module tb_synaptic_current_accumulator;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mw [N];

  synaptic_current_accumulator_if #(.N_INPUTS(N)) bus ();

  synaptic_current_accumulator #(.N_INPUTS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] spk;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(int'(h[9:0])) * pow2(-24);
    else        m = real'(int'(h[9:0]) + 1024) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2f(input real x);
    logic s;
    real  a, q, fr;
    int   e, m;
    s = (x < 0.0);
    a = s ? -x : x;
    e = -14;
    if (a >= pow2(-14)) while (a >= pow2(e + 1)) e++;
    q  = a * pow2(10 - e);
    m  = $rtoi(q);
    fr = q - real'(m);
    if (fr > 0.5 || (fr == 0.5 && (m % 2) == 1)) m++;
    if (a < pow2(-14)) return {s, 15'(m)};
    if (m == 2048) begin m = 1024; e++; end
    if (e > 15) return {s, 5'h1f, 10'h000};
    return {s, 5'(e + 15), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] fadd_model(input logic [15:0] a, input logic [15:0] b);
    real s;
    s = f2r(a) + f2r(b);
    if (s == 0.0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    return r2f(s);
  endfunction

  function automatic logic [15:0] sum_model(input logic [15:0] spk);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < N; i++) if (spk[i]) acc = fadd_model(acc, mw[i]);
    return acc;
  endfunction

  task automatic write_w(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Launches one sum and watches 20 cycles after the start edge.
  task automatic run_sum(input logic [15:0] spk, input bit ws, input int wr_j, input int rst_j,
                         input logic [3:0] waddr, input logic [15:0] wdata,
                         output logic [15:0] res, output int lat, output int bcnt,
                         output int np, output int nzb, output logic rb);
    @(negedge clk);
    bus.start = 1'b1; bus.spikes_in = spk;
    if (ws) begin bus.wr_en = 1'b1; bus.wr_addr = waddr; bus.wr_data = wdata; end
    res = 16'h7FFF; lat = -1; bcnt = 0; np = 0; nzb = 0; rb = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.spikes_in = 16'($urandom);
      bus.wr_en     = (j == wr_j);
      if (j == wr_j) begin bus.wr_addr = waddr; bus.wr_data = wdata; end
      reset = (rst_j >= 0) && (j >= rst_j) && (j < rst_j + 2);
      if (rst_j >= 0 && j == rst_j + 2) rb = bus.busy | bus.current_valid;
      if (bus.busy) bcnt++;
      if (bus.current_valid) begin np++; res = bus.current_out; lat = j; end
      else if (bus.current_out !== 16'h0000) nzb++;
    end
    bus.wr_en = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    vec_t        vt [7];
    logic [15:0] res, w, spk, pos0;
    int          lat, bcnt, np, nzb, pulses, gap;
    logic        rb;

    vt[0] = '{16'h000F, 16'h4400};
    vt[1] = '{16'h0000, 16'h0000};
    vt[2] = '{16'h0001, 16'h3C00};
    vt[3] = '{16'h0003, 16'h4000};
    vt[4] = '{16'h0007, 16'h4200};
    vt[5] = '{16'h00FF, 16'h4800};
    vt[6] = '{16'hFFFF, 16'h4C00};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.spikes_in = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",  {31'd0, bus.busy},          32'd0);
    chk("reset_valid", {31'd0, bus.current_valid}, 32'd0);
    chk("reset_out",   {16'd0, bus.current_out},   32'd0);
    reset = 1'b0;

    for (int i = 0; i < N; i++) write_w(4'(i), 16'h3C00);
    for (int v = 0; v < 7; v++) begin
      run_sum(vt[v].spk, 1'b0, -1, -1, 4'd0, 16'd0, res, lat, bcnt, np, nzb, rb);
      chk($sformatf("vec%0d_out", v), {16'd0, res}, {16'd0, vt[v].exp});
      chk($sformatf("vec%0d_pulses", v), np, 1);
      chk($sformatf("vec%0d_latency", v), lat, 17);
      chk($sformatf("vec%0d_busy_cycles", v), bcnt, 17);
      chk($sformatf("vec%0d_idle_zero", v), nzb, 0);
    end

    // +0.5 and -0.5 cancel to a signed zero
    write_w(4'd0, 16'h3800);
    write_w(4'd1, 16'hB800);
    run_sum(16'h0003, 1'b0, -1, -1, 4'd0, 16'd0, res, lat, bcnt, np, nzb, rb);
    chk("cancel_mag", {17'd0, res[14:0]}, 32'd0);
    chk("cancel_pulses", np, 1);

    // start held high: only spaced starts are accepted
    @(negedge clk);
    bus.start = 1'b1; bus.spikes_in = 16'h0001;
    pulses = 0; pos0 = 16'd0; gap = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.current_valid) begin
        if (pulses == 0) pos0 = 16'(j);
        else if (pulses == 1) gap = j - int'(pos0);
        pulses++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_spacing", gap, 18);
    repeat (25) @(negedge clk);

    // reset in the middle of ACCUM aborts and clears weights
    run_sum(16'hFFFF, 1'b0, -1, 5, 4'd0, 16'd0, res, lat, bcnt, np, nzb, rb);
    chk("abort_pulses", np, 0);
    chk("abort_outputs_cleared", {31'd0, rb}, 32'd0);
    run_sum(16'hFFFF, 1'b0, -1, -1, 4'd0, 16'd0, res, lat, bcnt, np, nzb, rb);
    chk("after_abort_out", {16'd0, res}, 32'd0);
    chk("after_abort_pulses", np, 1);

    // write while busy is dropped, write in IDLE lands
    run_sum(16'h0008, 1'b0, 3, -1, 4'd3, 16'h4000, res, lat, bcnt, np, nzb, rb);
    chk("busy_write_dropped", {16'd0, res}, 32'd0);
    write_w(4'd3, 16'h4000);
    run_sum(16'h0008, 1'b0, -1, -1, 4'd0, 16'd0, res, lat, bcnt, np, nzb, rb);
    chk("idle_write_used", {16'd0, res}, 32'h4000);
    run_sum(16'h0010, 1'b1, -1, -1, 4'd4, 16'h4200, res, lat, bcnt, np, nzb, rb);
    chk("write_with_start", {16'd0, res}, 32'h4200);

    // random weights and spike vectors against the reference model
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        w = {1'($urandom), 5'($urandom_range(0, 20)), 10'($urandom)};
        mw[i] = w;
        write_w(4'(i), w);
      end
      spk = 16'($urandom);
      if (t == 0) spk = 16'hFFFF;
      run_sum(spk, 1'b0, -1, -1, 4'd0, 16'd0, res, lat, bcnt, np, nzb, rb);
      chk($sformatf("rand%0d_out spk=%h", t, spk), {16'd0, res}, {16'd0, sum_model(spk)});
      chk($sformatf("rand%0d_pulses", t), np, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
